sprite_scan: RTL and testbench
==============================

SPRITE_SCAN -- requirements
Module: sprite_scan

Interface
REQ-001 Parameter NUM_OAM, default 40, number of OAM entries scanned per line.
REQ-002 Parameter MAX_SPR, default 10, maximum sprites selected per line.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 ce  input  1  clock enable; state advances only when ce=1.
REQ-006 line_start  input  1  pulse that starts a new line (scan plus fetch).
REQ-007 size16  input  1  sprite height select: 0 = 8 rows, 1 = 16 rows.
REQ-008 v_cnt  input  8  current line number.
REQ-009 oam_idx  output  6  OAM entry currently addressed (scan or fetch).
REQ-010 oam_y  input  8  Y byte of entry oam_idx, valid in the same cycle.
REQ-011 vram_rd  output  1  tile-data read request to the VRAM arbiter.
REQ-012 vram_ack  input  1  arbiter accepted the read; data is valid this cycle.
REQ-013 spr_ds  output  2  plane strobe to the sprite array: bit0 = low plane, bit1 = high plane.
REQ-014 spr_sel  output  6  OAM index of the sprite receiving spr_ds.
REQ-015 sel_count  output  4  number of sprites selected on this line.
REQ-016 busy  output  1  high in SCAN or FETCH.
REQ-017 done  output  1  high in DONE state.

Function
REQ-018 States: IDLE, SCAN, FETCH_LO, FETCH_HI, DONE; all transitions require ce=1.
REQ-019 line_start with ce=1 in any state: go to SCAN, scan counter = 0, sel_count = 0; this overrides all other transitions.
REQ-020 SCAN: one entry per ce cycle, index 0..NUM_OAM-1; oam_idx = scan counter.
REQ-021 Entry is visible when (v_cnt+16) >= oam_y and (v_cnt+16) < oam_y+height, computed in 9-bit arithmetic with no wrap; height = 16 if size16, else 8.
REQ-022 Visible entry with sel_count < MAX_SPR: its index is stored in list[sel_count] and sel_count increments; further visible entries are ignored once sel_count = MAX_SPR.
REQ-023 X position is not considered; an entry with x = 0 is still selected and counts toward the limit.
REQ-024 SCAN lasts exactly NUM_OAM ce cycles regardless of the number of entries selected.
REQ-025 After the last entry: go to FETCH_LO with fetch pointer = 0 if sel_count > 0, otherwise go to DONE.
REQ-026 FETCH_LO/FETCH_HI: vram_rd = 1 and oam_idx = list[fetch pointer].
REQ-027 FETCH_LO with vram_ack: spr_ds = 01 and spr_sel = list[ptr] in that cycle; go to FETCH_HI.
REQ-028 FETCH_HI with vram_ack: spr_ds = 10; increment the pointer; go to FETCH_LO, or to DONE if the pointer reaches sel_count.
REQ-029 Without vram_ack, the state holds and vram_rd stays asserted (wait states allowed).
REQ-030 spr_ds is a single-cycle pulse, zero in all other cycles; never 11.
REQ-031 vram_ack outside the fetch states is ignored.
REQ-032 DONE: hold until line_start; sel_count stays valid.
REQ-033 v_cnt and size16 are sampled per entry during SCAN; changing them mid-scan affects only later entries.

Reset
REQ-034 reset_n = 0 asynchronously forces: state IDLE, counters 0, list cleared, sel_count = 0, vram_rd = 0, spr_ds = 0, spr_sel = 0, oam_idx = 0, busy = 0, done = 0.
REQ-035 Reset mid-fetch drops the pending read immediately; no spr_ds pulse follows.

Verification
REQ-036 v_cnt = 0, size16 = 0, entry 3 y = 16, others y = 0, line_start -> after 40 ce: sel_count = 1, one read pair for index 3, done = 1.
REQ-037 All 40 entries y = 20, v_cnt = 10 -> sel_count = 10, indices 0..9 fetched in order, 20 spr_ds pulses alternating 01/10.
REQ-038 y = 16, v_cnt = 8: size16 = 0 -> not selected; size16 = 1 -> selected; v_cnt = 16 with size16 = 1 -> not selected.
REQ-039 vram_ack held low for 5 cycles in FETCH_LO -> vram_rd held for 5 cycles, no spr_ds; ack -> spr_ds = 01 in exactly that cycle.
REQ-040 line_start during FETCH_HI of sprite 2 -> next state SCAN, sel_count = 0, no spr_ds for the aborted read; reset_n pulse mid-SCAN -> all outputs 0 immediately.

Source files
------------

// File: rtl/sprite_scan.sv
// Per-line sprite evaluation: scans OAM Y bytes for entries visible on the current line,
// keeps up to MAX_SPR indices, then fetches low/high tile planes for each one.
module sprite_scan #(
    parameter int NUM_OAM = 40,
    parameter int MAX_SPR = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       line_start,
    input  logic       size16,
    input  logic [7:0] v_cnt,
    output logic [5:0] oam_idx,
    input  logic [7:0] oam_y,
    output logic       vram_rd,
    input  logic       vram_ack,
    output logic [1:0] spr_ds,
    output logic [5:0] spr_sel,
    output logic [3:0] sel_count,
    output logic       busy,
    output logic       done
);

    // state      | meaning
    // S_IDLE     | after reset, waiting for the first line_start
    // S_SCAN     | evaluating one OAM entry per ce cycle
    // S_FETCH_LO | low-plane read for list[ptr], waiting for vram_ack
    // S_FETCH_HI | high-plane read for list[ptr], waiting for vram_ack
    // S_DONE     | line finished, sel_count held until the next line_start
    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH_LO,
        S_FETCH_HI,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_OAM - 1);
    localparam logic [3:0] MAX_CNT  = 4'(MAX_SPR);

    state_t     state_q, state_d;
    logic [5:0] scan_q, scan_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] ptr_q, ptr_d;
    logic [5:0] list_q [MAX_SPR];
    logic [5:0] list_d [MAX_SPR];

    logic [8:0] line_pos;
    logic [8:0] y_top;
    logic [8:0] y_end;
    logic       visible;

    // Nine bits so that entries near the bottom of the Y range do not wrap.
    assign line_pos = {1'b0, v_cnt} + 9'd16;
    assign y_top    = {1'b0, oam_y};
    assign y_end    = y_top + (size16 ? 9'd16 : 9'd8);
    assign visible  = (line_pos >= y_top) && (line_pos < y_end);

    assign sel_count = sel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            scan_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < MAX_SPR; i++) list_q[i] <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            list_q  <= list_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        list_d  = list_q;
        oam_idx = '0;
        vram_rd = 1'b0;
        spr_ds  = 2'b00;
        spr_sel = '0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_SCAN: begin
                busy    = 1'b1;
                oam_idx = scan_q;
            end
            S_FETCH_LO: begin
                busy    = 1'b1;
                vram_rd = 1'b1;
                oam_idx = list_q[ptr_q];
                spr_sel = list_q[ptr_q];
                // A line_start in the same cycle aborts the read, so no strobe.
                if (ce && vram_ack && !line_start) spr_ds = 2'b01;
            end
            S_FETCH_HI: begin
                busy    = 1'b1;
                vram_rd = 1'b1;
                oam_idx = list_q[ptr_q];
                spr_sel = list_q[ptr_q];
                if (ce && vram_ack && !line_start) spr_ds = 2'b10;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase

        if (ce) begin
            if (line_start) begin
                state_d = S_SCAN;
                scan_d  = '0;
                sel_d   = '0;
                ptr_d   = '0;
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (visible && (sel_q < MAX_CNT)) begin
                            list_d[sel_q] = scan_q;
                            sel_d         = sel_q + 4'd1;
                        end
                        scan_d = scan_q + 6'd1;
                        if (scan_q == LAST_IDX) begin
                            scan_d  = '0;
                            ptr_d   = '0;
                            state_d = (sel_d != 4'd0) ? S_FETCH_LO : S_DONE;
                        end
                    end
                    S_FETCH_LO: begin
                        if (vram_ack) state_d = S_FETCH_HI;
                    end
                    S_FETCH_HI: begin
                        if (vram_ack) begin
                            ptr_d   = ptr_q + 4'd1;
                            state_d = ((ptr_q + 4'd1) == sel_q) ? S_DONE : S_FETCH_LO;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_scan.sv
// Directed bench for sprite_scan: OAM Y table modelled in the bench, strobes logged by a monitor.
module tb_sprite_scan;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       line_start;
    logic       size16;
    logic [7:0] v_cnt;
    logic [5:0] oam_idx;
    logic [7:0] oam_y;
    logic       vram_rd;
    logic       vram_ack;
    logic [1:0] spr_ds;
    logic [5:0] spr_sel;
    logic [3:0] sel_count;
    logic       busy;
    logic       done;

    logic [7:0] oam_mem [64];
    logic       ack_auto;
    logic       ack_man;
    logic [7:0] strobes [$];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign oam_y    = oam_mem[oam_idx];
    assign vram_ack = ack_auto ? vram_rd : ack_man;

    sprite_scan #(.NUM_OAM(40), .MAX_SPR(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .line_start (line_start),
        .size16     (size16),
        .v_cnt      (v_cnt),
        .oam_idx    (oam_idx),
        .oam_y      (oam_y),
        .vram_rd    (vram_rd),
        .vram_ack   (vram_ack),
        .spr_ds     (spr_ds),
        .spr_sel    (spr_sel),
        .sel_count  (sel_count),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (spr_ds != 2'b00) begin
            strobes.push_back({spr_ds, spr_sel});
            chk("ds_not_11", {30'd0, spr_ds == 2'b11}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] val);
        for (int i = 0; i < 64; i++) oam_mem[i] = val;
    endtask

    task automatic pulse_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic run_line(input string tag, input logic [3:0] exp_sel);
        int n = 0;
        strobes.delete();
        pulse_start();
        while (!(vram_rd || done) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_scan_len"}, n, 40);
        wait_done({tag, "_done"}, 200);
        chk({tag, "_sel"}, {28'd0, sel_count}, {28'd0, exp_sel});
    endtask

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b1;
        line_start = 1'b0;
        size16     = 1'b0;
        v_cnt      = 8'd0;
        ack_auto   = 1'b1;
        ack_man    = 1'b0;
        fill(8'd0);
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd", {31'd0, vram_rd}, 0);
        chk("rst_idx", {26'd0, oam_idx}, 0);
        chk("rst_sel", {28'd0, sel_count}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 0);

        // Single visible entry at index 3.
        fill(8'd0);
        oam_mem[3] = 8'd16;
        run_line("one", 4'd1);
        chk("one_cnt", strobes.size(), 2);
        if (strobes.size() == 2) begin
            chk("one_lo", {24'd0, strobes[0]}, {24'd0, 2'b01, 6'd3});
            chk("one_hi", {24'd0, strobes[1]}, {24'd0, 2'b10, 6'd3});
        end

        // Limit: all 40 visible, first 10 kept in order.
        fill(8'd20);
        v_cnt = 8'd10;
        run_line("full", 4'd10);
        chk("full_cnt", strobes.size(), 20);
        if (strobes.size() == 20) begin
            for (int i = 0; i < 10; i++) begin
                chk("full_lo", {24'd0, strobes[2*i]},   {24'd0, 2'b01, 6'(i)});
                chk("full_hi", {24'd0, strobes[2*i+1]}, {24'd0, 2'b10, 6'(i)});
            end
        end

        // Height boundaries; stray acks outside fetch must do nothing.
        fill(8'd200);
        oam_mem[5] = 8'd16;
        ack_auto = 1'b0;
        ack_man  = 1'b1;
        v_cnt = 8'd8; size16 = 1'b0;
        run_line("h8_edge", 4'd0);
        chk("h8_no_ds", strobes.size(), 0);
        ack_auto = 1'b1;
        size16 = 1'b1;
        run_line("h16_in", 4'd1);
        chk("h16_sel_idx", strobes.size() > 0 ? {24'd0, strobes[0]} : 32'hFFFF, {24'd0, 2'b01, 6'd5});
        v_cnt = 8'd16;
        run_line("h16_edge", 4'd0);
        // 250+16 = 266 must not wrap to 10.
        fill(8'd200);
        oam_mem[9] = 8'd255;
        v_cnt = 8'd250;
        run_line("nowrap", 4'd1);
        size16 = 1'b0;

        // Mid-scan v_cnt change plus ce stall.
        fill(8'd16);
        v_cnt = 8'd0;
        strobes.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        v_cnt = 8'd100;
        ce = 1'b0;
        tick(); tick(); tick();
        chk("ce_hold_idx", {26'd0, oam_idx}, 5);
        ce = 1'b1;
        wait_done("mid_done", 300);
        chk("mid_sel", {28'd0, sel_count}, 5);
        chk("mid_ds_cnt", strobes.size(), 10);

        // Wait states in FETCH_LO.
        fill(8'd200);
        oam_mem[7] = 8'd16;
        v_cnt = 8'd0;
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        strobes.delete();
        pulse_start();
        for (int i = 0; i < 40; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("ws_rd", {31'd0, vram_rd}, 1);
            chk("ws_ds", {30'd0, spr_ds}, 0);
            tick();
        end
        ack_man = 1'b1;
        #1;
        chk("ws_ack_lo", {24'd0, spr_ds, spr_sel}, {24'd0, 2'b01, 6'd7});
        tick();
        ack_man = 1'b0;
        #1;
        chk("ws_hi_wait", {30'd0, spr_ds}, 0);
        ack_man = 1'b1;
        #1;
        chk("ws_ack_hi", {24'd0, spr_ds, spr_sel}, {24'd0, 2'b10, 6'd7});
        tick();
        ack_man = 1'b0;
        chk("ws_done", {31'd0, done}, 1);
        chk("ws_ds_cnt", strobes.size(), 2);

        // Abort during FETCH_HI of sprite 2.
        fill(8'd20);
        v_cnt = 8'd10;
        strobes.delete();
        pulse_start();
        for (int i = 0; i < 40; i++) tick();
        ack_man = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ab_sel2", {26'd0, spr_sel}, 2);
        line_start = 1'b1;
        #1;
        chk("ab_no_ds", {30'd0, spr_ds}, 0);
        tick();
        line_start = 1'b0;
        ack_man = 1'b0;
        chk("ab_busy", {31'd0, busy}, 1);
        chk("ab_sel_cnt", {28'd0, sel_count}, 0);
        chk("ab_rd", {31'd0, vram_rd}, 0);
        chk("ab_ds_cnt", strobes.size(), 5);
        tick(); tick(); tick();
        chk("scan_idx3", {26'd0, oam_idx}, 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_outs", {busy, done, vram_rd, spr_ds, spr_sel, oam_idx, sel_count}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mrst_idle", {busy, done}, 0);

        // Reset with a read pending.
        fill(8'd200);
        oam_mem[7] = 8'd16;
        v_cnt = 8'd0;
        strobes.delete();
        pulse_start();
        for (int i = 0; i < 40; i++) tick();
        chk("frst_rd_pre", {31'd0, vram_rd}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("frst_rd", {31'd0, vram_rd}, 0);
        ack_man = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("frst_no_ds", strobes.size(), 0);
        chk("frst_idle", {busy, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
